// File: rtl/myproject_mul_pkg.sv
// Shared types, limits and width helper for the pipelined multiplier.
package myproject_mul_pkg;

  localparam int unsigned MAX_STAGE = 8;
  localparam int unsigned MAX_DOUT  = 64;

  // Signedness of the product as seen by the consumer
  typedef enum logic {
    UNS = 1'b0,
    SGN = 1'b1
  } res_mode_e;

  // Exact product width: both operands carry one extra extension bit
  function automatic int unsigned mul_prod_w(input int unsigned a, input int unsigned b);
    return a + b + 2;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_slot.sv
// One valid-tagged register slot of the multiplier pipeline.
// load carries the upstream valid; the slot captures whenever it is empty
// or its current content is leaving (advance), so bubbles collapse.
module myproject_mul_pipe_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid
);

  // Capture upstream beat when free; hold payload otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (!valid || advance) begin
      valid <= load;
      if (load) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined integer multiplier with valid/ready flow control and
// per-beat operand signedness.
// Optional feature: define MYPROJECT_MUL_SAT_EN to clamp out-of-range
// products (when dout_WIDTH < din0_WIDTH + din1_WIDTH) and flag dout_ovf;
// otherwise the product wraps and dout_ovf is tied low.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int unsigned din0_WIDTH = 14,
  parameter int unsigned din1_WIDTH = 12,
  parameter int unsigned dout_WIDTH = 26,
  parameter int unsigned NUM_STAGE  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din0_signed,
  input  logic                  din1_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_ovf
);

  localparam int unsigned P    = din0_WIDTH + din1_WIDTH;
  localparam int unsigned PW   = mul_prod_w(din0_WIDTH, din1_WIDTH);
  localparam int unsigned EXTW = (PW > dout_WIDTH) ? PW : dout_WIDTH;
  localparam int unsigned PLW  = dout_WIDTH + 1;

  if (NUM_STAGE > MAX_STAGE) begin : g_chk_stage
    $error("NUM_STAGE exceeds MAX_STAGE");
  end
  if (dout_WIDTH > MAX_DOUT) begin : g_chk_dout
    $error("dout_WIDTH exceeds MAX_DOUT");
  end

  logic                   a_sb;
  logic                   b_sb;
  logic [PW-1:0]          a_x;
  logic [PW-1:0]          b_x;
  logic signed [PW-1:0]   prod;
  logic signed [EXTW-1:0] ext;
  logic [dout_WIDTH-1:0]  res_c;
  logic                   ovf_c;

  // Operand extension: sign bit only when the operand is flagged signed
  assign a_sb = din0_signed & din0[din0_WIDTH-1];
  assign b_sb = din1_signed & din1[din1_WIDTH-1];
  assign a_x  = {{(PW-din0_WIDTH){a_sb}}, din0};
  assign b_x  = {{(PW-din1_WIDTH){b_sb}}, din1};

  // Exact product; an unsigned-mode product is never negative, so sign
  // extension of prod doubles as zero extension for unsigned results
  assign prod = a_x * b_x;
  assign ext  = EXTW'(prod);

`ifdef MYPROJECT_MUL_SAT_EN
  if (dout_WIDTH < P) begin : g_sat
    res_mode_e mode;
    logic      ovf_s;
    logic      ovf_u;

    assign mode  = (din0_signed | din1_signed) ? SGN : UNS;
    assign ovf_s = (prod[PW-1:dout_WIDTH-1] != {(PW-dout_WIDTH+1){prod[PW-1]}});
    assign ovf_u = (prod[PW-1:dout_WIDTH] != '0);

    // Clamp to the representable range of the result signedness
    always_comb begin
      ovf_c = 1'b0;
      res_c = dout_WIDTH'(ext);
      if (mode == SGN) begin
        if (ovf_s) begin
          ovf_c = 1'b1;
          res_c = prod[PW-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                             : {1'b0, {(dout_WIDTH-1){1'b1}}};
        end
      end else if (ovf_u) begin
        ovf_c = 1'b1;
        res_c = '1;
      end
    end
  end else begin : g_nosat
    assign res_c = dout_WIDTH'(ext);
    assign ovf_c = 1'b0;
  end
`else
  assign res_c = dout_WIDTH'(ext);
  assign ovf_c = 1'b0;
`endif

  if (NUM_STAGE == 0) begin : g_comb
    // Zero-latency build: straight combinational pass-through
    assign in_ready  = out_ready;
    assign out_valid = in_valid;
    assign dout      = res_c;
    assign dout_ovf  = ovf_c;
  end else begin : g_pipe
    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_slot
      logic           vld;
      logic           adv;
      logic           free;
      logic           up_vld;
      logic [PLW-1:0] up_pl;
      logic [PLW-1:0] pl;

      // Upstream source: the multiplier for slot 0, else the previous slot
      if (i == 0) begin : g_head
        assign up_vld = in_valid;
        assign up_pl  = {ovf_c, res_c};
      end else begin : g_mid
        assign up_vld = g_slot[i-1].vld;
        assign up_pl  = g_slot[i-1].pl;
      end

      // Content leaves when the downstream consumer can take it
      if (i == NUM_STAGE - 1) begin : g_tail
        assign adv = vld & out_ready;
      end else begin : g_fwd
        assign adv = vld & g_slot[i+1].free;
      end

      assign free = ~vld | adv;

      myproject_mul_pipe_slot #(
        .W (PLW)
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (up_vld),
        .advance (adv),
        .din     (up_pl),
        .dout    (pl),
        .valid   (vld)
      );
    end

    assign in_ready          = g_slot[0].free;
    assign out_valid         = g_slot[NUM_STAGE-1].vld;
    assign {dout_ovf, dout}  = g_slot[NUM_STAGE-1].pl;
  end

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Self-checking bench for myproject_mul_pipe: directed vector tables,
// backpressure / reset sequences and a randomized scoreboard run.
module tb_myproject_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Main DUT: 14 x 12 -> 26, 3 stages
  logic        m_iv, m_ir, m_sa, m_sb, m_ov, m_or, m_ovf;
  logic [13:0] m_a;
  logic [11:0] m_b;
  logic [25:0] m_d;

  // Narrow-output DUT: 14 x 12 -> 8, 2 stages
  logic        s_iv, s_ir, s_sa, s_sb, s_ov, s_or, s_ovf;
  logic [13:0] s_a;
  logic [11:0] s_b;
  logic [7:0]  s_d;

  // Combinational DUT: 14 x 12 -> 26, 0 stages
  logic        z_iv, z_ir, z_sa, z_sb, z_ov, z_or, z_ovf;
  logic [13:0] z_a;
  logic [11:0] z_b;
  logic [25:0] z_d;

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .NUM_STAGE(3)) dut (
    .clk(clk), .reset(rst), .in_valid(m_iv), .in_ready(m_ir), .din0(m_a), .din1(m_b),
    .din0_signed(m_sa), .din1_signed(m_sb), .out_valid(m_ov), .out_ready(m_or),
    .dout(m_d), .dout_ovf(m_ovf));

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(8), .NUM_STAGE(2)) dut8 (
    .clk(clk), .reset(rst), .in_valid(s_iv), .in_ready(s_ir), .din0(s_a), .din1(s_b),
    .din0_signed(s_sa), .din1_signed(s_sb), .out_valid(s_ov), .out_ready(s_or),
    .dout(s_d), .dout_ovf(s_ovf));

  myproject_mul_pipe #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26), .NUM_STAGE(0)) dut0 (
    .clk(clk), .reset(rst), .in_valid(z_iv), .in_ready(z_ir), .din0(z_a), .din1(z_b),
    .din0_signed(z_sa), .din1_signed(z_sb), .out_valid(z_ov), .out_ready(z_or),
    .dout(z_d), .dout_ovf(z_ovf));

  typedef struct {
    logic [13:0] a;
    logic [11:0] b;
    bit          sa;
    bit          sb;
    logic [25:0] d;
    bit          ovf;
  } vec_t;

  typedef struct {
    logic [25:0] d;
    bit          ovf;
    int          t;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: operands as integers, exact product, then clamp or wrap
  function automatic void model(input int w0, input int w1, input int wd,
                                input logic [31:0] a, input logic [31:0] b,
                                input bit sa, input bit sb,
                                output logic [63:0] d, output bit ovf);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (sa && a[w0-1]) av = av - (longint'(1) << w0);
    if (sb && b[w1-1]) bv = bv - (longint'(1) << w1);
    p   = av * bv;
    ovf = 1'b0;
`ifdef MYPROJECT_MUL_SAT_EN
    if (wd < w0 + w1) begin
      longint hi, lo;
      if (sa || sb) begin
        hi = (longint'(1) << (wd - 1)) - 1;
        lo = -(longint'(1) << (wd - 1));
      end else begin
        hi = (longint'(1) << wd) - 1;
        lo = 0;
      end
      if (p > hi) begin p = hi; ovf = 1'b1; end
      else if (p < lo) begin p = lo; ovf = 1'b1; end
    end
`endif
    d = 64'(p) & ((64'd1 << wd) - 64'd1);
  endfunction

  // One main-DUT cycle against the occupancy/latency scoreboard
  task automatic m_step(output bit acc);
    exp_t        e;
    logic [63:0] md;
    bit          mo;
    acc = 1'b0;
    @(negedge clk);
    chk("m_in_ready", 64'(m_ir), 64'((q.size() < 3) || m_or));
    chk("m_out_valid", 64'(m_ov), 64'((q.size() > 0) && (q[0].t <= cyc)));
    if (m_ov && m_or && q.size() > 0) begin
      e = q.pop_front();
      chk("m_sb_dout", 64'(m_d), 64'(e.d));
      chk("m_sb_ovf", 64'(m_ovf), 64'(e.ovf));
    end
    if (m_iv && m_ir) begin
      model(14, 12, 26, 32'(m_a), 32'(m_b), m_sa, m_sb, md, mo);
      e.d   = 26'(md);
      e.ovf = mo;
      e.t   = cyc + 3;
      q.push_back(e);
      acc = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic m_rand_ops();
    m_a  = 14'($urandom);
    m_b  = 12'($urandom);
    m_sa = 1'($urandom);
    m_sb = 1'($urandom);
  endtask

  // Single isolated beat on the main DUT with latency measurement
  task automatic m_beat(input vec_t v);
    int lat;
    lat  = 0;
    m_a  = v.a; m_b = v.b; m_sa = v.sa; m_sb = v.sb;
    m_iv = 1'b1; m_or = 1'b1;
    @(negedge clk);
    chk("m_tab_in_ready", 64'(m_ir), 64'd1);
    @(posedge clk); #1;
    m_iv = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (m_ov) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("m_tab_latency", 64'(lat), 64'd3);
    chk("m_tab_dout", 64'(m_d), 64'(v.d));
    chk("m_tab_ovf", 64'(m_ovf), 64'(v.ovf));
    @(posedge clk); #1;
  endtask

  // Single isolated beat on the narrow DUT
  task automatic s_beat(input vec_t v);
    int lat;
    lat  = 0;
    s_a  = v.a; s_b = v.b; s_sa = v.sa; s_sb = v.sb;
    s_iv = 1'b1; s_or = 1'b1;
    @(negedge clk);
    chk("s_in_ready", 64'(s_ir), 64'd1);
    @(posedge clk); #1;
    s_iv = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s_ov) begin lat = k; break; end
      @(posedge clk); #1;
    end
    chk("s_latency", 64'(lat), 64'd2);
    chk("s_dout", 64'(s_d), 64'(v.d[7:0]));
    chk("s_ovf", 64'(s_ovf), 64'(v.ovf));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        mt[6];
    vec_t        st[7];
    vec_t        v;
    logic [63:0] md;
    bit          mo;
    bit          acc;
    int          n;

    mt[0] = '{14'h3FFF, 12'hFFF, 1'b0, 1'b0, 26'd67088385, 1'b0};
    mt[1] = '{14'h3FFF, 12'd5,   1'b1, 1'b0, 26'h3FFFFFB,  1'b0};
    mt[2] = '{14'h3FFF, 12'd5,   1'b0, 1'b0, 26'd81915,    1'b0};
    mt[3] = '{14'h2000, 12'h800, 1'b1, 1'b1, 26'h1000000,  1'b0};
    mt[4] = '{14'h3FFF, 12'h800, 1'b0, 1'b1, 26'h2000800,  1'b0};
    mt[5] = '{14'd0,    12'hFFF, 1'b1, 1'b1, 26'd0,        1'b0};

`ifdef MYPROJECT_MUL_SAT_EN
    st[0] = '{14'd100,  12'd100, 1'b1, 1'b1, 26'h7F, 1'b1};
    st[1] = '{14'h3F9C, 12'd100, 1'b1, 1'b1, 26'h80, 1'b1};
    st[2] = '{14'd200,  12'd2,   1'b0, 1'b0, 26'hFF, 1'b1};
`else
    st[0] = '{14'd100,  12'd100, 1'b1, 1'b1, 26'h10, 1'b0};
    st[1] = '{14'h3F9C, 12'd100, 1'b1, 1'b1, 26'hF0, 1'b0};
    st[2] = '{14'd200,  12'd2,   1'b0, 1'b0, 26'h90, 1'b0};
`endif
    st[3] = '{14'd5,    12'hFFD, 1'b1, 1'b1, 26'hF1, 1'b0};
    st[4] = '{14'd15,   12'd17,  1'b0, 1'b0, 26'hFF, 1'b0};
    st[5] = '{14'd127,  12'd1,   1'b1, 1'b1, 26'h7F, 1'b0};
    st[6] = '{14'h3FC0, 12'd2,   1'b1, 1'b1, 26'h80, 1'b0};

    rst  = 1'b1;
    m_iv = 1'b0; m_or = 1'b0; m_a = '0; m_b = '0; m_sa = 1'b0; m_sb = 1'b0;
    s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_sa = 1'b0; s_sb = 1'b0;
    z_iv = 1'b0; z_or = 1'b0; z_a = '0; z_b = '0; z_sa = 1'b0; z_sb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, with out_ready low so in_ready reflects empty slots
    @(negedge clk);
    chk("rst_out_valid", 64'(m_ov), 64'd0);
    chk("rst_dout", 64'(m_d), 64'd0);
    chk("rst_ovf", 64'(m_ovf), 64'd0);
    chk("rst_in_ready", 64'(m_ir), 64'd1);
    chk("rst_s_out_valid", 64'(s_ov), 64'd0);
    chk("rst_s_dout", 64'(s_d), 64'd0);
    @(posedge clk); #1;

    // Zero-stage build follows its inputs in the same cycle
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        z_iv = 1'b1; z_or = 1'b0; z_a = 14'h3FFF; z_b = 12'hFFF; z_sa = 1'b0; z_sb = 1'b0;
      end else begin
        z_iv = 1'($urandom); z_or = 1'($urandom);
        z_a = 14'($urandom); z_b = 12'($urandom); z_sa = 1'($urandom); z_sb = 1'($urandom);
      end
      #1;
      model(14, 12, 26, 32'(z_a), 32'(z_b), z_sa, z_sb, md, mo);
      chk("z_out_valid", 64'(z_ov), 64'(z_iv));
      chk("z_in_ready", 64'(z_ir), 64'(z_or));
      chk("z_dout", 64'(z_d), md);
      chk("z_ovf", 64'(z_ovf), 64'(mo));
    end

    // Directed tables
    for (int i = 0; i < 6; i++) m_beat(mt[i]);
    for (int i = 0; i < 7; i++) s_beat(st[i]);

    // Random isolated beats on the narrow DUT against the model
    for (int i = 0; i < 20; i++) begin
      v.a = 14'($urandom); v.b = 12'($urandom); v.sa = 1'($urandom); v.sb = 1'($urandom);
      model(14, 12, 8, 32'(v.a), 32'(v.b), v.sa, v.sb, md, mo);
      v.d = 26'(md); v.ovf = mo;
      s_beat(v);
    end

    // Backpressure: 10 beats with out_ready alternating
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      m_iv = 1'b1; m_rand_ops();
      m_or = (k % 2 == 0);
      m_step(acc);
      n += int'(acc);
    end
    m_iv = 1'b0;
    for (int k = 0; k < 20; k++) begin
      m_or = (k % 2 == 0);
      m_step(acc);
    end
    chk("bp_beats", 64'(n), 64'd10);
    chk("bp_drained", 64'(q.size()), 64'd0);

    // Reset with two beats in flight; in_valid held high during reset
    m_or = 1'b0; m_iv = 1'b1;
    m_rand_ops(); m_step(acc);
    m_rand_ops(); m_step(acc);
    m_iv = 1'b0;
    m_step(acc);
    chk("mid_inflight", 64'(q.size()), 64'd2);
    rst = 1'b1; m_iv = 1'b1;
    @(posedge clk); cyc++; #1;
    rst = 1'b0; m_iv = 1'b0;
    q.delete();
    m_or = 1'b1;
    repeat (4) m_step(acc);
    m_iv = 1'b1; m_rand_ops();
    m_step(acc);
    m_iv = 1'b0;
    repeat (5) m_step(acc);
    chk("mid_post_beat", 64'(q.size()), 64'd0);

    // Randomized stream
    for (int k = 0; k < 600; k++) begin
      m_iv = ($urandom_range(3) != 0);
      m_rand_ops();
      m_or = ($urandom_range(4) > 1);
      m_step(acc);
    end
    m_iv = 1'b0; m_or = 1'b1;
    repeat (10) m_step(acc);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/myproject_mul_pipe.md
# myproject_mul_pipe

Parametrised pipelined integer multiplier with valid/ready flow control, per-transaction operand signedness and a configurable output width. It is the generic successor of the fixed-width, zero-latency HLS multiplier cores in the `myproject` datapath. It sits between streaming producers and consumers in the RDMA-side inference pipeline, where backpressure must stall the product stream without losing data.

## Interface
- `din0_WIDTH`, 14: operand A width, 2..32.
- `din1_WIDTH`, 12: operand B width, 2..32.
- `dout_WIDTH`, 26: result width, 2..64.
- `NUM_STAGE`, 3: pipeline depth, 0..8.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: input beat accepted when `in_valid && in_ready`.
- `din0`  in  din0_WIDTH: operand A.
- `din1`  in  din1_WIDTH: operand B.
- `din0_signed`  in  1: A is two's complement (1) or unsigned (0); travels with the beat.
- `din1_signed`  in  1: B is two's complement (1) or unsigned (0); travels with the beat.
- `out_valid`  out  1: result beat valid.
- `out_ready`  in  1: consumer accepts when `out_valid && out_ready`.
- `dout`  out  dout_WIDTH: product.
- `dout_ovf`  out  1: product did not fit in dout_WIDTH (saturation build only).

## Operation
- **Operand extension:** each operand is extended by one bit, with a sign bit if its signed flag is set and a zero otherwise.
- **Product width:** the product is computed at P+2 bits, where P = din0_WIDTH + din1_WIDTH, so every mode combination is exact.
- **Result signedness:** the result is signed if either flag is set, unsigned otherwise.
- **dout_WIDTH ≥ P:** `dout` is the product sign- or zero-extended per the result signedness; `dout_ovf` = 0.
- **dout_WIDTH < P, default build:** `dout` keeps the low dout_WIDTH bits (wrap); `dout_ovf` = 0.
- **Pipeline:** NUM_STAGE register slots, each holding {product, ovf, valid}. Slot i loads when slot i is empty or slot i advances, so bubbles collapse.
- **Ready chain:** `in_ready` = slot 0 is free or advancing. The last slot advances on `out_ready`.
- **NUM_STAGE = 0:** purely combinational path; `in_ready` = `out_ready`, `out_valid` = `in_valid`, and `dout` follows the inputs.
- **Beat order:** beats are never dropped, duplicated or reordered.
- **Data during stalls:** slot data is held while stalled; `dout` is stable whenever `out_valid && !out_ready`.

## Timing
- **Reset values:**
  - All slot valid bits = 0, so `out_valid` = 0.
  - `dout` = 0 and `dout_ovf` = 0.
  - `in_ready` = 1 in the first cycle after reset deasserts, for NUM_STAGE > 0.
- **Latency:** a beat accepted at edge n appears with `out_valid` = 1 after edge n+NUM_STAGE, when unstalled.
- **Throughput:** one beat per cycle while `out_ready` = 1.
- **Full pipeline:** when all slots are valid and `out_ready` = 0, `in_ready` = 0 in the same cycle (combinational).
- **Simultaneous accept and emit:** on a full pipeline with `out_ready` = 1, accept and emit happen in the same cycle and occupancy is unchanged.
- **Reset mid-operation:** all in-flight beats are discarded on the edge where `reset` = 1. `in_valid` is ignored while `reset` = 1.
- **Ready/valid dependency:** `in_ready` may depend combinationally on `out_ready`. `out_valid` never depends on `out_ready`.

## Configuration
- **`MYPROJECT_MUL_SAT_EN` defined, with dout_WIDTH < P:**
  - Results outside the representable range clamp to max or min for the result signedness.
  - Signed range is −2^(dout_WIDTH−1) .. 2^(dout_WIDTH−1)−1; unsigned range is 0 .. 2^dout_WIDTH−1.
  - `dout_ovf` = 1 for that beat, aligned with `dout`.
- **Undefined:** wrap behaviour; the overflow comparison is not synthesised and `dout_ovf` is tied to 0.

## Structure
- **Package `myproject_mul_pkg`:**
  - Function `mul_prod_w(a, b)` returning a + b + 2.
  - Localparam limits: MAX_STAGE = 8, MAX_DOUT = 64.
  - Result-mode enum: UNS, SGN.
- **Sub-module `myproject_mul_pipe_slot`:**
  - One valid-tagged register slot, parametrised on payload width.
  - Ports: clk, reset, load, advance, payload in/out, valid.
  - The top level uses a generate loop of NUM_STAGE instances.
- **Top level:** the combinational multiply, extension and saturation logic precede slot 0.

## Test plan
- **Unsigned, full width:** 14/12/26, NUM_STAGE = 3, din0 = 16383, din1 = 4095, both unsigned → `dout` = 67088385 after 3 cycles, `dout_ovf` = 0.
- **Mixed signedness:** din0 = 0x3FFF signed (−1), din1 = 5 unsigned → `dout` = −5 (0x3FFFFFB); with both unsigned → 81915.
- **Saturation:** dout_WIDTH = 8, signed 100 × 100.
  - `MYPROJECT_MUL_SAT_EN` defined → `dout` = 127, `dout_ovf` = 1.
  - Undefined → `dout` = 0x10 (low byte of 10000), `dout_ovf` = 0.
- **Backpressure:** stream of 10 beats with `out_ready` toggling on a 1-0-1 pattern → exact in-order products. `in_ready` = 0 only while 3 slots are full and `out_ready` = 0.
- **Reset mid-flight:** `reset` pulsed for 1 cycle with 2 beats in the pipeline → no `out_valid` for those beats. The next accepted beat emerges after 3 cycles.
- **NUM_STAGE = 0:** `out_valid`/`dout` follow `in_valid`/operands in the same cycle; `in_ready` mirrors `out_ready`.
